// File: rtl/level_two_if.sv
// Controller and flash-pin bundle for the level_two NAND bus sequencer.
// The slave modport is the sequencer side; the master modport is the controller/pad side.
interface level_two_if #(
  parameter int DQ_W        = 8,
  parameter int NUM_TARGETS = 2,
  parameter int TGT_W       = 1
);
  logic                   op_valid;
  logic                   op_ready;
  logic [2:0]             op_type;
  logic [DQ_W-1:0]        op_data;
  logic [TGT_W-1:0]       op_target;
  logic                   op_last;
  logic                   wp_enable;
  logic                   done;
  logic                   err;
  logic [DQ_W-1:0]        rd_data;
  logic                   cle;
  logic                   ale;
  logic                   we_n;
  logic                   re_n;
  logic [NUM_TARGETS-1:0] ce_n;
  logic                   wp_n;
  logic [NUM_TARGETS-1:0] rb_n;
  logic [DQ_W-1:0]        dq_out;
  logic                   dq_oe;
  logic [DQ_W-1:0]        dq_in;

  modport slave (
    input  op_valid, op_type, op_data, op_target, op_last, wp_enable, rb_n, dq_in,
    output op_ready, done, err, rd_data, cle, ale, we_n, re_n, ce_n, wp_n, dq_out, dq_oe
  );

  modport master (
    output op_valid, op_type, op_data, op_target, op_last, wp_enable, rb_n, dq_in,
    input  op_ready, done, err, rd_data, cle, ale, we_n, re_n, ce_n, wp_n, dq_out, dq_oe
  );
endinterface

// File: rtl/level_two.sv
// NAND-flash bus sequencer: runs one controller operation at a time and produces
// timed CLE/ALE/WE#/RE#/CE# strobes, with synchronised ready/busy wait and timeout.
module level_two #(
  parameter int DQ_W        = 8,
  parameter int NUM_TARGETS = 2,
  parameter int TGT_W       = 1,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 3,
  parameter int T_HOLD      = 2,
  parameter int T_WB        = 10,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clock_100,
  input  logic       rst,
  level_two_if.slave bus
);

  localparam int M1      = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int M2      = (M1 > T_HOLD) ? M1 : T_HOLD;
  localparam int M3      = (M2 > T_WB) ? M2 : T_WB;
  localparam int CNT_MAX = (M3 > TIMEOUT) ? M3 : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_CMD  = 3'd0;
  localparam logic [2:0] OP_ADDR = 3'd1;
  localparam logic [2:0] OP_DOUT = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT_WB, S_WAIT_RB, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             type_q;
  logic [DQ_W-1:0]        data_q;
  logic [TGT_W-1:0]       tgt_q;
  logic                   last_q;
  logic [NUM_TARGETS-1:0] ce_n_q;
  logic [DQ_W-1:0]        rd_data_q;
  logic                   wp_n_q;
  logic [NUM_TARGETS-1:0] rb_meta_q, rb_sync_q;
  logic                   live_q;

  logic                   op_ready;
  logic                   accept;
  logic                   op_illegal;
  logic                   cnt_last;
  logic                   rb_ready;
  logic                   done;
  logic [NUM_TARGETS-1:0] ce_sel_n;

  assign op_ready   = live_q && (state_q == S_IDLE);
  assign accept     = bus.op_valid && op_ready;
  assign op_illegal = (bus.op_type > OP_WAIT) || (int'(bus.op_target) >= NUM_TARGETS);
  assign cnt_last   = (cnt_q == '0);
  assign rb_ready   = rb_sync_q[tgt_q];

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_ce_sel
    assign ce_sel_n[gi] = (int'(bus.op_target) != gi);
  end

  // State register plus datapath registers; live_q holds op_ready low until the first edge after reset.
  always_ff @(posedge clock_100 or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      type_q    <= '0;
      data_q    <= '0;
      tgt_q     <= '0;
      last_q    <= 1'b0;
      ce_n_q    <= '1;
      rd_data_q <= '0;
      wp_n_q    <= 1'b0;
      rb_meta_q <= '0;
      rb_sync_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
      wp_n_q    <= ~bus.wp_enable;
      rb_meta_q <= bus.rb_n;
      rb_sync_q <= rb_meta_q;
      if (accept) begin
        type_q <= bus.op_type;
        data_q <= bus.op_data;
        tgt_q  <= bus.op_target;
        last_q <= bus.op_last;
        if (!op_illegal) begin
          ce_n_q <= ce_sel_n;
        end
      end else if (done && last_q) begin
        ce_n_q <= '1;
      end
      if (state_q == S_PULSE && cnt_last && type_q == OP_DOUT) begin
        rd_data_q <= bus.dq_in;
      end
    end
  end

  // Next-state: the single down-counter is reloaded on every state entry and saturates at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_illegal) begin
            state_d = S_ERR;
          end else if (bus.op_type == OP_WAIT) begin
            state_d = S_WAIT_WB;
            cnt_d   = CNT_W'(T_WB - 1);
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(T_SETUP - 1);
          end
        end
      end
      S_SETUP: if (cnt_last) begin
        state_d = S_PULSE;
        cnt_d   = CNT_W'(T_PULSE - 1);
      end
      S_PULSE: if (cnt_last) begin
        state_d = S_HOLD;
        cnt_d   = CNT_W'(T_HOLD - 1);
      end
      S_HOLD: if (cnt_last) state_d = S_IDLE;
      S_WAIT_WB: if (cnt_last) begin
        state_d = S_WAIT_RB;
        cnt_d   = CNT_W'(TIMEOUT - 1);
      end
      S_WAIT_RB: if (rb_ready || cnt_last) state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so an asynchronous reset clears the strobes at once.
  always_comb begin
    done        = 1'b0;
    bus.err     = 1'b0;
    bus.cle     = 1'b0;
    bus.ale     = 1'b0;
    bus.we_n    = 1'b1;
    bus.re_n    = 1'b1;
    bus.dq_oe   = 1'b0;
    bus.dq_out  = '0;
    case (state_q)
      S_SETUP, S_PULSE, S_HOLD: begin
        bus.cle   = (type_q == OP_CMD);
        bus.ale   = (type_q == OP_ADDR);
        bus.dq_oe = (type_q != OP_DOUT);
        if (type_q != OP_DOUT) bus.dq_out = data_q;
        if (state_q == S_PULSE) begin
          bus.we_n = (type_q == OP_DOUT);
          bus.re_n = (type_q != OP_DOUT);
        end
        if (state_q == S_HOLD && cnt_last) done = 1'b1;
      end
      S_WAIT_RB: begin
        done    = rb_ready || cnt_last;
        bus.err = !rb_ready && cnt_last;
      end
      S_ERR: begin
        done    = 1'b1;
        bus.err = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done     = done;
  assign bus.op_ready = op_ready;
  assign bus.ce_n     = ce_n_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.wp_n     = wp_n_q;

endmodule

// File: tb/tb_level_two.sv
// Directed bench for level_two: bus-op strobe timing, CE# handling, DOUT capture,
// ready/busy wait, timeout, illegal op and asynchronous reset mid-operation.
module tb_level_two;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   fail_cnt;

  level_two_if #(.DQ_W(8), .NUM_TARGETS(2), .TGT_W(1)) bus ();

  level_two #(.TIMEOUT(100)) dut (
    .clock_100 (clk),
    .rst       (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] bus_vec();
    return {bus.cle, bus.ale, bus.we_n, bus.re_n, bus.dq_oe, bus.done, bus.err,
            bus.ce_n, bus.dq_out};
  endfunction

  task automatic start_op(input logic [2:0] typ, input logic [7:0] data,
                          input logic tgt, input logic last);
    int n;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("op_ready_wait", 32'(bus.op_ready), 32'd1);
    bus.op_valid  = 1'b1;
    bus.op_type   = typ;
    bus.op_data   = data;
    bus.op_target = tgt;
    bus.op_last   = last;
    tick();
    bus.op_valid  = 1'b0;
  endtask

  // Accepts one CMD/ADDR/DIN/DOUT op and checks cycles 1..7 after accept; ends in cycle 7.
  task automatic run_bus_op(input string name, input logic [2:0] typ, input logic [7:0] data,
                            input logic tgt, input logic last, input logic [1:0] exp_ce);
    logic [16:0] exp;
    logic        pulse;
    start_op(typ, data, tgt, last);
    for (int k = 1; k <= 7; k++) begin
      if (typ == 3'd3) bus.dq_in = (k < 3) ? 8'h5A : ((k <= 5) ? 8'hA5 : 8'h3C);
      pulse = (k >= 3 && k <= 5);
      exp = {typ == 3'd0, typ == 3'd1, !(pulse && typ != 3'd3), !(pulse && typ == 3'd3),
             typ != 3'd3, k == 7, 1'b0, exp_ce, (typ != 3'd3) ? data : 8'h00};
      chk($sformatf("%s_c%0d", name, k), 32'(bus_vec()), 32'(exp));
      if (k == 7 && typ == 3'd3) chk($sformatf("%s_rd_data", name), 32'(bus.rd_data), 32'h0A5);
      if (k < 7) tick();
    end
    $display("op %s type=%0d data=0x%02h tgt=%0d last=%0d done", name, typ, data, tgt, last);
  endtask

  task automatic run_wait(input string name, input logic tgt, input int rise_at,
                          input int exp_cyc, input logic exp_err);
    int   first;
    logic e;
    first = 0;
    e     = 1'b0;
    start_op(3'd4, 8'h00, tgt, 1'b1);
    for (int k = 1; k <= 150; k++) begin
      if (k == rise_at) bus.rb_n[1] = 1'b1;
      if (bus.done === 1'b1) begin
        first = k;
        e     = bus.err;
        break;
      end
      tick();
    end
    chk($sformatf("%s_done_cycle", name), 32'(first), 32'(exp_cyc));
    chk($sformatf("%s_err", name), 32'(e), 32'(exp_err));
    $display("op %s tgt=%0d done at cycle %0d err=%0d", name, tgt, first, e);
    tick();
  endtask

  initial begin
    chk_cnt       = 0;
    fail_cnt      = 0;
    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_type   = 3'd0;
    bus.op_data   = 8'h00;
    bus.op_target = 1'b0;
    bus.op_last   = 1'b0;
    bus.wp_enable = 1'b0;
    bus.rb_n      = 2'b11;
    bus.dq_in     = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", 32'(bus_vec()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00}));
    chk("rst_wp_n", 32'(bus.wp_n), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_op_ready_pre", 32'(bus.op_ready), 32'd0);
    tick();
    chk("rel_op_ready_post", 32'(bus.op_ready), 32'd1);
    chk("rel_wp_n", 32'(bus.wp_n), 32'd1);
    bus.wp_enable = 1'b1;
    tick();
    chk("wp_assert", 32'(bus.wp_n), 32'd0);
    bus.wp_enable = 1'b0;
    tick();

    // CMD 0x70 to target 0, CE released after done
    run_bus_op("cmd70", 3'd0, 8'h70, 1'b0, 1'b1, 2'b10);
    tick();
    chk("cmd70_ce_release", 32'(bus.ce_n), 32'h3);
    chk("cmd70_idle_ready", 32'(bus.op_ready), 32'd1);

    // ADDR 0x00 holding CE, then ADDR 0x12 back-to-back on the other die
    run_bus_op("addr00", 3'd1, 8'h00, 1'b0, 1'b0, 2'b10);
    tick();
    chk("addr00_ce_held", 32'(bus.ce_n), 32'h2);
    run_bus_op("addr12", 3'd1, 8'h12, 1'b1, 1'b1, 2'b01);
    tick();
    chk("addr12_ce_release", 32'(bus.ce_n), 32'h3);

    // DIN and DOUT
    run_bus_op("din", 3'd2, 8'hC3, 1'b1, 1'b0, 2'b01);
    tick();
    run_bus_op("dout", 3'd3, 8'h00, 1'b0, 1'b1, 2'b10);
    tick();
    chk("dout_rd_hold", 32'(bus.rd_data), 32'h0A5);

    // Ready/busy: die 0 ready (ignored during T_WB), die 1 rises at cycle 40, then timeout
    bus.rb_n = 2'b01;
    repeat (3) tick();
    run_wait("wait_rdy0", 1'b0, 0, 11, 1'b0);
    run_wait("wait_rise1", 1'b1, 40, 42, 1'b0);
    bus.rb_n = 2'b01;
    repeat (3) tick();
    run_wait("wait_tmo1", 1'b1, 0, 110, 1'b1);
    bus.rb_n = 2'b11;

    // Illegal op_type 6
    start_op(3'd6, 8'h55, 1'b0, 1'b1);
    chk("ill_c1", 32'(bus_vec()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 8'h00}));
    tick();
    chk("ill_c2_ready", 32'(bus.op_ready), 32'd1);
    chk("ill_c2_done", 32'(bus.done), 32'd0);
    $display("op illegal type=6 checked");

    // Asynchronous reset in the middle of a DIN pulse
    start_op(3'd2, 8'h3C, 1'b1, 1'b0);
    repeat (3) tick();
    chk("rstmid_pulse_we_n", 32'(bus.we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_vec", 32'(bus_vec()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00}));
    chk("rstmid_op_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_rel_pre", 32'(bus.op_ready), 32'd0);
    tick();
    chk("rstmid_rel_post", 32'(bus.op_ready), 32'd1);
    $display("op reset mid-pulse checked");

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
